// File: rtl/fast_window_gen.sv
// Streaming 3x3 window generator for the FAST keypoint filter: two line buffers,
// a column shift register and a registered window output with its centre coordinate.
module fast_window_gen #(
  parameter  int IMG_W = 640,
  parameter  int IMG_H = 480,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [7:0]    in_pixel,
  output logic [23:0]   filter_input_0,
  output logic [23:0]   filter_input_1,
  output logic [23:0]   filter_input_2,
  output logic          out_valid,
  output logic [XW-1:0] center_x,
  output logic [YW-1:0] center_y,
  output logic          frame_done
);

  // Handshake: in_valid alone qualifies a pixel; there is no backpressure, so every
  // accepted pixel is consumed in its own cycle and its window appears one cycle later.
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [XW-1:0]   r_x, w_x_next, w_px;
  logic [YW-1:0]   r_y, w_y_next, w_py;
  logic [7:0]      r_lb0 [IMG_W];
  logic [7:0]      r_lb1 [IMG_W];
  // Columns are packed {row y-2, row y-1, row y}; r_col_a is column x-2, r_col_b column x-1.
  logic [23:0]     r_col_a, r_col_b, w_new_col;
  logic            w_accept, w_qual, w_last_x, w_last;
  logic [23:0]     r_row0, r_row1, r_row2;
  logic [XW-1:0]   r_cx;
  logic [YW-1:0]   r_cy;
  logic            r_valid, r_done;

  assign w_accept  = in_valid & (in_sof | (r_state == S_RUN));
  assign w_px      = in_sof ? '0 : r_x;
  assign w_py      = in_sof ? '0 : r_y;
  assign w_last_x  = (w_px == XW'(IMG_W - 1));
  assign w_last    = w_last_x & (w_py == YW'(IMG_H - 1));
  assign w_qual    = w_accept & (w_px >= XW'(2)) & (w_py >= YW'(2));
  assign w_new_col = {r_lb0[w_px], r_lb1[w_px], in_pixel};

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    if (w_accept) begin
      if (w_last) begin
        w_state_next = S_IDLE;
        w_x_next     = '0;
        w_y_next     = '0;
      end else if (w_last_x) begin
        w_state_next = S_RUN;
        w_x_next     = '0;
        w_y_next     = w_py + YW'(1);
      end else begin
        w_state_next = S_RUN;
        w_x_next     = w_px + XW'(1);
        w_y_next     = w_py;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_col_a <= '0;
      r_col_b <= '0;
      r_row0  <= '0;
      r_row1  <= '0;
      r_row2  <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_valid <= w_qual;
      r_done  <= w_qual & w_last;
      if (w_accept) begin
        r_col_a <= r_col_b;
        r_col_b <= w_new_col;
      end
      if (w_qual) begin
        r_row0 <= {w_new_col[23:16], r_col_b[23:16], r_col_a[23:16]};
        r_row1 <= {w_new_col[15:8],  r_col_b[15:8],  r_col_a[15:8]};
        r_row2 <= {w_new_col[7:0],   r_col_b[7:0],   r_col_a[7:0]};
        r_cx   <= w_px - XW'(1);
        r_cy   <= w_py - YW'(1);
      end
    end
  end

  // Line buffers are never cleared: stale rows are masked by the x>=2, y>=2 qualification.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_lb0[w_px] <= r_lb1[w_px];
      r_lb1[w_px] <= in_pixel;
    end
  end

  assign filter_input_0 = r_row0;
  assign filter_input_1 = r_row1;
  assign filter_input_2 = r_row2;
  assign out_valid      = r_valid;
  assign frame_done     = r_done;
  assign center_x       = r_cx;
  assign center_y       = r_cy;

endmodule

// File: tb/tb_fast_window_gen.sv
// Bench for fast_window_gen on an 8x6 image: a frame-array reference model plus
// fixed window tables for the ramp frame and directed restart/reset/back-to-back cases.
module tb_fast_window_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int EW = 72 + XW + YW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_sof;
  logic [7:0]    in_pixel;
  logic [23:0]   filter_input_0, filter_input_1, filter_input_2;
  logic          out_valid, frame_done;
  logic [XW-1:0] center_x;
  logic [YW-1:0] center_y;

  fast_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .filter_input_0(filter_input_0), .filter_input_1(filter_input_1),
    .filter_input_2(filter_input_2), .out_valid(out_valid),
    .center_x(center_x), .center_y(center_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_win, n_done;

  // Reference model: the current frame as a 2D array plus scan position.
  logic [7:0]    img [H][W];
  bit            m_run;
  int            m_x, m_y;
  logic [EW-2:0] held;
  logic [EW-1:0] exp_q[$];
  logic [71:0]   log_w [H][W];

  typedef struct {
    int          cx;
    int          cy;
    logic [23:0] f0;
    logic [23:0] f1;
    logic [23:0] f2;
  } win_vec_t;
  win_vec_t ramp_tab [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_pixel(input logic v, input logic s, input logic [7:0] p);
    logic [71:0] rows;
    if (!v) return;
    if (s) begin
      m_x = 0; m_y = 0; m_run = 1'b1;
    end
    if (!m_run) return;
    img[m_y][m_x] = p;
    if (m_x >= 2 && m_y >= 2) begin
      rows = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          rows[(2 - r) * 24 + c * 8 +: 8] = img[m_y - 2 + r][m_x - 2 + c];
      exp_q.push_back({rows, XW'(m_x - 1), YW'(m_y - 1), (m_x == W - 1 && m_y == H - 1)});
    end
    if (m_x == W - 1 && m_y == H - 1) begin
      m_x = 0; m_y = 0; m_run = 1'b0;
    end else if (m_x == W - 1) begin
      m_x = 0; m_y++;
    end else begin
      m_x++;
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    logic          ev;
    ev = (exp_q.size() > 0);
    e  = '0;
    if (ev) e = exp_q.pop_front();
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("window", {filter_input_0, filter_input_1, filter_input_2, center_x, center_y, frame_done}, e);
      held = e[EW-1:1];
    end else begin
      chk("frame_done_idle", frame_done, 1'b0);
      chk("hold", {filter_input_0, filter_input_1, filter_input_2, center_x, center_y}, held);
    end
    if (out_valid) begin
      log_w[center_y][center_x] = {filter_input_0, filter_input_1, filter_input_2};
      n_win++;
      if (frame_done) n_done++;
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    reset = 1'b0; in_valid = v; in_sof = s; in_pixel = p;
    model_pixel(v, s, p);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'($urandom_range(0, 1)); in_sof = 1'b0; in_pixel = 8'($urandom);
    @(posedge clk);
    #1;
    m_run = 1'b0; m_x = 0; m_y = 0; held = '0; exp_q.delete();
    chk("reset_outputs", {filter_input_0, filter_input_1, filter_input_2, center_x, center_y,
                          out_valid, frame_done}, '0);
  endtask

  // Drives pixels 0..n_pix-1 of a frame; pixel = x + 10*y + off unless randomised.
  task automatic run_frame(input int off, input int gap_pct, input bit rnd, input int n_pix);
    int x, y;
    for (int i = 0; i < n_pix; i++) begin
      x = i % W;
      y = i / W;
      while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      step(1'b1, (i == 0), rnd ? 8'($urandom) : 8'(x + 10 * y + off));
    end
  endtask

  task automatic check_ramp_tab(input string tag);
    for (int i = 0; i < 4; i++)
      chk(tag, log_w[ramp_tab[i].cy][ramp_tab[i].cx],
          {ramp_tab[i].f0, ramp_tab[i].f1, ramp_tab[i].f2});
  endtask

  task automatic clear_stats();
    n_win = 0; n_done = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) log_w[y][x] = '0;
  endtask

  initial begin
    // Ramp-frame windows worked out by hand from pixel = x + 10*y.
    ramp_tab[0] = '{cx: 1, cy: 1, f0: 24'h020100, f1: 24'h0C0B0A, f2: 24'h161514};
    ramp_tab[1] = '{cx: 3, cy: 2, f0: 24'h0E0D0C, f1: 24'h181716, f2: 24'h222120};
    ramp_tab[2] = '{cx: 1, cy: 4, f0: 24'h201F1E, f1: 24'h2A2928, f2: 24'h343332};
    ramp_tab[3] = '{cx: 6, cy: 4, f0: 24'h252423, f1: 24'h2F2E2D, f2: 24'h393837};

    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    m_run = 1'b0; m_x = 0; m_y = 0; held = '0;
    clear_stats();
    do_reset();
    do_reset();

    // Pixels without in_sof are dropped in IDLE.
    clear_stats();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("idle_drop_windows", n_win, 0);

    // Continuous ramp frame.
    clear_stats();
    run_frame(0, 0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("ramp_windows", n_win, 24);
    chk("ramp_done", n_done, 1);
    check_ramp_tab("ramp_tab");

    // Same frame with random gaps in in_valid.
    clear_stats();
    run_frame(0, 40, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("gap_windows", n_win, 24);
    chk("gap_done", n_done, 1);
    check_ramp_tab("gap_tab");

    // Restart with in_sof at (5,3): 9 windows from the abandoned frame, then 24 new.
    clear_stats();
    run_frame(0, 0, 0, 3 * W + 5);
    run_frame(100, 0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("restart_windows", n_win, 9 + 24);
    chk("restart_done", n_done, 1);
    chk("restart_first_row0", log_w[1][1][71:48], 24'h666564);

    // Reset mid-frame at (4,4), then pixels without in_sof.
    clear_stats();
    run_frame(0, 0, 0, 4 * W + 4);
    clear_stats();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    chk("post_reset_windows", n_win, 0);
    run_frame(0, 0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("after_reset_windows", n_win, 24);
    check_ramp_tab("after_reset_tab");

    // in_sof on the slot of the last pixel wins: no window or frame_done for frame 1's end.
    clear_stats();
    run_frame(0, 0, 0, W * H - 1);
    run_frame(100, 0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("sof_last_windows", n_win, 23 + 24);
    chk("sof_last_done", n_done, 1);

    // Back-to-back frames.
    clear_stats();
    run_frame(0, 0, 0, W * H);
    run_frame(100, 0, 0, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("b2b_windows", n_win, 48);
    chk("b2b_done", n_done, 2);
    chk("b2b_f2_row0", log_w[1][1][71:48], 24'h666564);

    // Random pixel frames with gaps.
    clear_stats();
    for (int f = 0; f < 3; f++) run_frame(0, 30, 1, W * H);
    step(1'b0, 1'b0, 8'h00);
    chk("rand_windows", n_win, 72);
    chk("rand_done", n_done, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
